// File: rtl/xxhash32_stream_feeder_if.sv
// Bundles the byte stream, xxhash32 core strobes and digest result port of the feeder.
// The feeder connects through the slave modport; the environment uses the master modport.
interface xxhash32_stream_feeder_if;
  logic [7:0]  s_byte;
  logic        s_valid;
  logic        s_last;
  logic        s_ready;
  logic        core_seed_in;
  logic        core_add_to_hash;
  logic        core_request_hash;
  logic [31:0] core_input_bytes;
  logic        core_hash_ready;
  logic [31:0] core_output_hash;
  logic [31:0] m_hash;
  logic        m_error;
  logic        m_valid;
  logic        m_ready;

  modport slave (
    input  s_byte, s_valid, s_last,
    output s_ready,
    output core_seed_in, core_add_to_hash, core_request_hash, core_input_bytes,
    input  core_hash_ready, core_output_hash,
    output m_hash, m_error, m_valid,
    input  m_ready
  );

  modport master (
    output s_byte, s_valid, s_last,
    input  s_ready,
    input  core_seed_in, core_add_to_hash, core_request_hash, core_input_bytes,
    output core_hash_ready, core_output_hash,
    input  m_hash, m_error, m_valid,
    output m_ready
  );
endinterface

// File: rtl/xxhash32_stream_feeder.sv
// Packs a last-flagged byte stream into little-endian words, sequences the xxhash32 core
// strobes for one message at a time and returns the digest on a valid/ready result port.
module xxhash32_stream_feeder #(
  parameter int WORD_SIZE      = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [WORD_SIZE-1:0]       i_cfg_seed,
  xxhash32_stream_feeder_if.slave    io_bus
);

  localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEED,
    S_COLLECT,
    S_FLUSH,
    S_REQ,
    S_WAIT,
    S_OUT
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [1:0]           r_count;
  logic [WORD_SIZE-9:0] r_pack;
  logic                 r_error;
  logic [TIMER_W-1:0]   r_timer;
  logic                 r_seed_in;
  logic                 r_add;
  logic                 r_req;
  logic [WORD_SIZE-1:0] r_in;
  logic [WORD_SIZE-1:0] r_m_hash;
  logic                 r_m_error;
  logic                 r_m_valid;
  logic                 w_accept;
  logic                 w_timeout;
  logic                 w_word_done;

  assign w_accept    = (r_state == S_COLLECT) && io_bus.s_valid;
  assign w_word_done = w_accept && (r_count == 2'd3);
  assign w_timeout   = (r_timer == TIMER_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (io_bus.s_valid) w_next = S_SEED;
      S_SEED:    w_next = S_COLLECT;
      S_COLLECT: if (w_accept && io_bus.s_last) w_next = (r_count == 2'd3) ? S_FLUSH : S_REQ;
      S_FLUSH:   w_next = S_REQ;
      S_REQ:     w_next = S_WAIT;
      S_WAIT:    if (io_bus.core_hash_ready || w_timeout) w_next = S_OUT;
      S_OUT:     if (io_bus.m_ready) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // Strobes are registered from the next state so each one lines up with its own state cycle;
  // the add strobe instead follows the 4th byte so packing never stalls the stream.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_count   <= 2'd0;
      r_pack    <= '0;
      r_error   <= 1'b0;
      r_timer   <= '0;
      r_seed_in <= 1'b0;
      r_add     <= 1'b0;
      r_req     <= 1'b0;
      r_in      <= '0;
      r_m_hash  <= '0;
      r_m_error <= 1'b0;
      r_m_valid <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_seed_in <= (r_state == S_IDLE) && (w_next == S_SEED);
      r_add     <= w_word_done;
      r_req     <= (w_next == S_REQ);
      r_m_valid <= (w_next == S_OUT);

      if ((r_state == S_IDLE) && (w_next == S_SEED)) begin
        r_in <= i_cfg_seed;
      end else if (w_word_done) begin
        r_in <= {io_bus.s_byte, r_pack};
      end

      if (w_accept) begin
        r_count <= r_count + 2'd1;
        case (r_count)
          2'd0:    r_pack[7:0]   <= io_bus.s_byte;
          2'd1:    r_pack[15:8]  <= io_bus.s_byte;
          2'd2:    r_pack[23:16] <= io_bus.s_byte;
          default: ;
        endcase
        if (io_bus.s_last) begin
          // A message ending mid-word drops its tail bytes and is flagged in the result.
          r_count <= 2'd0;
          r_pack  <= '0;
          if (r_count != 2'd3) r_error <= 1'b1;
        end
      end

      if (r_state == S_REQ) r_timer <= '0;
      if (r_state == S_WAIT) begin
        r_timer <= r_timer + TIMER_W'(1);
        if (io_bus.core_hash_ready) begin
          r_m_hash  <= io_bus.core_output_hash;
          r_m_error <= r_error;
        end else if (w_timeout) begin
          r_m_hash  <= '0;
          r_m_error <= 1'b1;
        end
      end

      if ((r_state == S_OUT) && io_bus.m_ready) begin
        r_m_hash  <= '0;
        r_m_error <= 1'b0;
        r_error   <= 1'b0;
        r_count   <= 2'd0;
        r_pack    <= '0;
        r_timer   <= '0;
      end
    end
  end

  assign io_bus.s_ready           = (r_state == S_COLLECT);
  assign io_bus.core_seed_in      = r_seed_in;
  assign io_bus.core_add_to_hash  = r_add;
  assign io_bus.core_request_hash = r_req;
  assign io_bus.core_input_bytes  = r_in;
  assign io_bus.m_hash            = r_m_hash;
  assign io_bus.m_error           = r_m_error;
  assign io_bus.m_valid           = r_m_valid;

endmodule
